ped_request_ctrl: RTL and testbench



---
 rtl/ped_request_ctrl.sv | 91 +++++++++
 tb/tb_ped_request_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/ped_request_ctrl.sv
// rtl/ped_request_ctrl.sv - pedestrian push-button conditioner feeding pass_request
// Synchronizes and debounces the button, latches a request, serves it during green, then locks out.
module ped_request_ctrl #(
  parameter int DB_CYCLES      = 4,
  parameter int LOCKOUT_CYCLES = 20,
  parameter int SHORT_LIMIT    = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_raw,
  input  logic       green,
  input  logic [7:0] clock,
  output logic       pass_request,
  output logic       req_pending,
  output logic       btn_db
);

  localparam int             DBW       = $clog2(DB_CYCLES);
  localparam logic [DBW-1:0] DB_MAX    = DBW'(DB_CYCLES - 1);
  localparam logic [7:0]     LOCK_INIT = 8'(LOCKOUT_CYCLES);
  localparam logic [7:0]     SHORT_LIM = 8'(SHORT_LIMIT);

  logic           s1_q, s1_d;
  logic           s2_q, s2_d;
  logic           btn_db_q, btn_db_d;
  logic [DBW-1:0] db_cnt_q, db_cnt_d;
  logic           req_pending_q, req_pending_d;
  logic           pass_request_q, pass_request_d;
  logic [7:0]     lock_cnt_q, lock_cnt_d;
  logic           press;

  always_comb begin
    s1_d     = btn_raw;
    s2_d     = s1_q;
    btn_db_d = btn_db_q;
    db_cnt_d = db_cnt_q;
    press    = 1'b0;
    if (s2_q == btn_db_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_MAX) begin
      btn_db_d = s2_q;
      db_cnt_d = '0;
      press    = s2_q;
    end else begin
      db_cnt_d = db_cnt_q + DBW'(1);
    end
  end

  // A request during green is either served (long green left) or dropped as redundant.
  always_comb begin
    pass_request_d = 1'b0;
    req_pending_d  = req_pending_q;
    lock_cnt_d     = (lock_cnt_q != 8'd0) ? lock_cnt_q - 8'd1 : 8'd0;
    if (req_pending_q && green) begin
      req_pending_d = 1'b0;
      if (clock > SHORT_LIM) begin
        pass_request_d = 1'b1;
        lock_cnt_d     = LOCK_INIT;
      end
    end
    // Only a lockout already expired before this edge lets a new press through.
    if (press && (lock_cnt_q == 8'd0)) begin
      req_pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q           <= 1'b0;
      s2_q           <= 1'b0;
      btn_db_q       <= 1'b0;
      db_cnt_q       <= '0;
      req_pending_q  <= 1'b0;
      pass_request_q <= 1'b0;
      lock_cnt_q     <= 8'd0;
    end else begin
      s1_q           <= s1_d;
      s2_q           <= s2_d;
      btn_db_q       <= btn_db_d;
      db_cnt_q       <= db_cnt_d;
      req_pending_q  <= req_pending_d;
      pass_request_q <= pass_request_d;
      lock_cnt_q     <= lock_cnt_d;
    end
  end

  assign pass_request = pass_request_q;
  assign req_pending  = req_pending_q;
  assign btn_db       = btn_db_q;

endmodule

// File: tb/tb_ped_request_ctrl.sv
// tb/tb_ped_request_ctrl.sv - directed and random stimulus against a behavioural model
module tb_ped_request_ctrl;

  localparam int DB = 4;
  localparam int LK = 20;
  localparam int SL = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_raw = 1'b0;
  logic       green = 1'b0;
  logic [7:0] clock = 8'd0;
  logic       pass_request, req_pending, btn_db;

  int vectors = 0;
  int miscompares = 0;

  bit m_db = 0, m_pend = 0, m_pulse = 0;
  int m_lock = 0;
  bit rq[$];
  bit sq[$];

  ped_request_ctrl #(
    .DB_CYCLES(DB),
    .LOCKOUT_CYCLES(LK),
    .SHORT_LIMIT(SL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_raw(btn_raw),
    .green(green),
    .clock(clock),
    .pass_request(pass_request),
    .req_pending(req_pending),
    .btn_db(btn_db)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  // Debounced level flips once the last DB synchronized samples all disagree with it.
  task automatic model_edge(input bit r, input bit raw, input bit g, input int c);
    bit s2, all_diff, rise, old_pend;
    int old_lock;
    if (r) begin
      m_db = 0; m_pend = 0; m_pulse = 0; m_lock = 0;
      rq.delete(); sq.delete();
      for (int i = 0; i < 2; i++) rq.push_back(1'b0);
      for (int i = 0; i < DB; i++) sq.push_back(1'b0);
    end else begin
      s2 = rq[rq.size() - 2];
      sq.push_back(s2);
      all_diff = 1;
      for (int i = 0; i < DB; i++)
        if (sq[sq.size() - 1 - i] == m_db) all_diff = 0;
      old_pend = m_pend;
      old_lock = m_lock;
      rise = 0;
      if (all_diff) begin
        m_db = !m_db;
        rise = m_db;
      end
      m_pulse = 0;
      if (m_lock > 0) m_lock--;
      if (old_pend && g) begin
        m_pend = 0;
        if (c > SL) begin
          m_pulse = 1;
          m_lock = LK;
        end
      end
      if (rise && old_lock == 0) m_pend = 1;
      rq.push_back(raw);
      while (rq.size() > 4) void'(rq.pop_front());
      while (sq.size() > DB) void'(sq.pop_front());
    end
  endtask

  task automatic step(input bit r, input bit raw, input bit g, input int c);
    rst = r; btn_raw = raw; green = g; clock = 8'(c);
    @(posedge clk);
    model_edge(r, raw, g, c);
    #1;
    chk("pass_request", pass_request, m_pulse);
    chk("req_pending", req_pending, m_pend);
    chk("btn_db", btn_db, m_db);
  endtask

  task automatic idle(input int n, input bit g, input int c);
    for (int i = 0; i < n; i++) step(0, 0, g, c);
  endtask

  initial begin
    int run, rraw, rg, rc;

    // reset with button held, then debounce out of reset
    for (int i = 0; i < 5; i++) begin
      step(1, 1, 0, 0);
      chk("rst_pass", pass_request, 1'b0);
      chk("rst_pend", req_pending, 1'b0);
      chk("rst_db", btn_db, 1'b0);
    end
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 0, 0);
      if (i == DB) chk("rst_db_before", btn_db, 1'b0);
      if (i == DB + 1) chk("rst_db_rise", btn_db, 1'b1);
    end
    idle(6, 0, 0);
    idle(4, 1, 40);
    idle(30, 1, 40);

    // clean press during long green
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 1, 40);
      if (i == DB + 1) begin
        chk("press_pend_e5", req_pending, 1'b1);
        chk("press_nopulse_e5", pass_request, 1'b0);
      end
      if (i == DB + 2) begin
        chk("press_pulse_e6", pass_request, 1'b1);
        chk("press_pend_clr_e6", req_pending, 1'b0);
      end
      if (i == DB + 3) chk("press_pulse_end_e7", pass_request, 1'b0);
    end
    idle(30, 1, 40);

    // short bounce is rejected
    for (int i = 0; i < 3; i++) step(0, 1, 1, 40);
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 1, 40);
      chk("bounce_db", btn_db, 1'b0);
      chk("bounce_pend", req_pending, 1'b0);
      chk("bounce_pass", pass_request, 1'b0);
    end

    // press during red, green arrives later
    for (int i = 0; i < 10; i++) step(0, 1, 0, 60);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 60);
    chk("red_pend_held", req_pending, 1'b1);
    step(0, 0, 1, 60);
    chk("red_pulse_on_green", pass_request, 1'b1);
    idle(30, 1, 60);

    // redundant request: short green left, and the exact boundary value
    for (int i = 0; i < 10; i++) step(0, 1, 1, 8);
    chk("short_nopulse", pass_request, 1'b0);
    idle(10, 1, 8);
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 1, 40);
      if (i == DB + 2) chk("no_lock_after_drop", pass_request, 1'b1);
    end
    idle(30, 1, 40);
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 1, SL);
      chk("boundary_nopulse", pass_request, 1'b0);
    end
    idle(10, 1, SL);

    // press inside lockout is ignored, later press served
    for (int i = 0; i < 6; i++) step(0, 1, 1, 40);
    idle(6, 1, 40);
    for (int i = 0; i < 6; i++) step(0, 1, 1, 40);
    chk("lockout_ignored", req_pending, 1'b0);
    idle(14, 1, 40);
    for (int i = 0; i < 8; i++) step(0, 1, 1, 40);
    idle(30, 1, 40);

    // reset in the middle of a pending request
    for (int i = 0; i < 8; i++) step(0, 1, 0, 40);
    step(1, 1, 0, 40);
    chk("midrst_pend", req_pending, 1'b0);
    chk("midrst_db", btn_db, 1'b0);
    idle(12, 0, 40);

    // random runs of button, lamp and countdown
    for (int k = 0; k < 150; k++) begin
      run  = $urandom_range(1, 8);
      rraw = $urandom_range(0, 1);
      rg   = ($urandom_range(0, 3) != 0) ? 1 : 0;
      rc   = $urandom_range(0, 20);
      for (int i = 0; i < run; i++)
        step(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0, rraw[0], rg[0], rc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
